ex_result_stage: RTL

Execute-to-memory pipeline stage that consumes the ALU's `result_o`/`flag_o` together with the instruction's decoded control fields. It resolves branches and jumps into a registered PC redirect, selects write-back data, and holds memory-request fields. Results are buffered in a two-entry skid buffer so backpressure from the memory stage never creates a combinational ready path to decode.

---
 rtl/ex_result_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ex_result_stage.sv
// Execute result stage: resolves branch/jump redirects, selects write-back data and buffers the result.
// Two-entry skid buffer (M + S) keeps ready_o a function of registers only.
module ex_result_stage #(
  parameter int RESET_PC_ALIGN = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_flag_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        branch_i,
  input  logic        jal_i,
  input  logic        jalr_i,
  input  logic        gpr_we_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [2:0]  mem_size_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        flush_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] wb_data_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  output logic [4:0]  rd_addr_o,
  output logic        gpr_we_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        wb_from_mem_o,
  output logic [2:0]  mem_size_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        misaligned_o
);

  typedef struct packed {
    logic [31:0] wb_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [4:0]  rd_addr;
    logic        gpr_we;
    logic        mem_req;
    logic        mem_we;
    logic        wb_from_mem;
    logic [2:0]  mem_size;
  } entry_t;

  logic        r_rst_q;
  logic        r_m_vld;
  logic        r_s_vld;
  entry_t      r_m;
  entry_t      r_s;
  logic        r_redirect;
  logic        r_misaligned;
  logic [31:0] r_redirect_pc;

  logic        w_accept;
  logic        w_taken;
  logic [31:0] w_target;
  logic        w_misaligned;
  logic        w_redirect;
  entry_t      w_in;

  assign ready_o      = r_rst_q & ~r_s_vld;
  assign w_accept     = valid_i & ready_o & ~flush_i;
  assign w_taken      = jal_i | jalr_i | (branch_i & alu_flag_i);
  assign w_target     = jalr_i ? {alu_result_i[31:1], 1'b0} : (pc_i + imm_i);
  assign w_misaligned = (RESET_PC_ALIGN != 0) && w_target[1];
  assign w_redirect   = w_accept & w_taken;

  always_comb begin
    w_in             = '0;
    w_in.wb_data     = (wb_sel_i == 2'd2) ? (pc_i + 32'd4) : alu_result_i;
    w_in.mem_addr    = alu_result_i;
    w_in.mem_wd      = rs2_data_i;
    w_in.rd_addr     = rd_addr_i;
    w_in.gpr_we      = gpr_we_i;
    w_in.mem_req     = mem_req_i;
    w_in.mem_we      = mem_we_i;
    w_in.wb_from_mem = (wb_sel_i == 2'd1);
    w_in.mem_size    = mem_size_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rst_q       <= 1'b0;
      r_m_vld       <= 1'b0;
      r_s_vld       <= 1'b0;
      r_m           <= '0;
      r_s           <= '0;
      r_redirect    <= 1'b0;
      r_misaligned  <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_rst_q      <= 1'b1;
      // redirect follows acceptance, so output backpressure never delays it
      r_redirect   <= w_redirect & ~w_misaligned;
      r_misaligned <= w_redirect & w_misaligned;
      if (w_redirect && !w_misaligned) begin
        r_redirect_pc <= w_target;
      end

      if (flush_i) begin
        r_m_vld <= 1'b0;
        r_s_vld <= 1'b0;
      end else if (r_s_vld) begin
        if (ready_i) begin
          r_m     <= r_s;
          r_s_vld <= 1'b0;
        end
      end else if (r_m_vld) begin
        if (ready_i) begin
          r_m_vld <= w_accept;
          if (w_accept) begin
            r_m <= w_in;
          end
        end else if (w_accept) begin
          r_s     <= w_in;
          r_s_vld <= 1'b1;
        end
      end else if (w_accept) begin
        r_m     <= w_in;
        r_m_vld <= 1'b1;
      end
    end
  end

  assign valid_o       = r_m_vld;
  assign wb_data_o     = r_m.wb_data;
  assign mem_addr_o    = r_m.mem_addr;
  assign mem_wd_o      = r_m.mem_wd;
  assign rd_addr_o     = r_m.rd_addr;
  assign gpr_we_o      = r_m_vld & r_m.gpr_we;
  assign mem_req_o     = r_m_vld & r_m.mem_req;
  assign mem_we_o      = r_m_vld & r_m.mem_we;
  assign wb_from_mem_o = r_m.wb_from_mem;
  assign mem_size_o    = r_m.mem_size;
  assign redirect_o    = r_redirect;
  assign redirect_pc_o = r_redirect_pc;
  assign misaligned_o  = r_misaligned;

endmodule
